keypad_scan_display: RTL

//   Scanning 4x4 hex-keypad controller with multi-digit seven-segment output.

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_scan_display_seg7_mux.sv | 62 ++++++
 rtl/keypad_scan_display.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the keypad scanner and its display mux.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;
  localparam logic [3:0] COL_NONE = 4'b1111;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Position of the low bit in an active-low one-hot column word.
  function automatic logic [1:0] onehot_col_idx(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic single_low(input logic [3:0] col);
    return (col == 4'b1110) || (col == 4'b1101) || (col == 4'b1011) || (col == 4'b0111);
  endfunction

endpackage

// File: rtl/keypad_scan_display_seg7_mux.sv
// Time-multiplexes the hex digit buffer onto a shared seven-segment bus.
// Leading-zero blanking is compiled in when KEYPAD_LZ_BLANK_EN is defined.
module seg7_mux
  import keypad_pkg::*;
#(
  parameter int          NUM_DIGITS  = 4,
  parameter logic [15:0] REFRESH_DIV = 16'd5000,
  parameter int          CNT_W       = $clog2(NUM_DIGITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DIGITS-1:0][3:0] digits,
  input  logic [CNT_W-1:0]           count,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an
);

  localparam int RW = (REFRESH_DIV > 16'd1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [RW-1:0] REF_LOAD = RW'(REFRESH_DIV - 16'd1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [RW-1:0] ref_cnt;
  logic [IW-1:0] idx;
  logic          blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= REF_LOAD;
      idx     <= '0;
    end else if (ref_cnt == '0) begin
      ref_cnt <= REF_LOAD;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
    end
  end

`ifdef KEYPAD_LZ_BLANK_EN
  // Digit 0 always lights; higher digits only once that many keys were entered.
  always_comb begin
    blank = 1'b0;
    if ((idx != '0) && (CNT_W'(idx) >= count)) blank = 1'b1;
  end
`else
  logic unused_count;
  assign unused_count = ^count;
  assign blank = 1'b0;
`endif

  // an and seg share one register stage so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= '0;
      an  <= '1;
    end else begin
      seg <= blank ? 7'h00 : hex_to_seg7(digits[idx]);
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: rtl/keypad_scan_display.sv
// 4x4 hex keypad scanner with debounce, one event per press and a shifting
// seven-segment display buffer. KEYPAD_LZ_BLANK_EN enables leading-zero blanking.
//
//   state    | meaning
//   SCAN     | rows rotate each sample period, waiting for a single-key sample
//   DEBOUNCE | row frozen, counting samples equal to the latched column
//   HELD     | key reported, waiting for DEBOUNCE_CNT all-high samples
module keypad_scan_display
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd1000,
  parameter int          DEBOUNCE_CNT = 4,
  parameter int          NUM_DIGITS   = 4,
  parameter logic [15:0] REFRESH_DIV  = 16'd5000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [3:0]            row_out,
  input  logic [3:0]            col_in,
  input  logic                  clr,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int SW = (SCAN_DIV > 16'd1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE_CNT + 1);
  localparam int NW = $clog2(NUM_DIGITS + 1);
  localparam logic [SW-1:0] SCAN_LOAD = SW'(SCAN_DIV - 16'd1);

  scan_state_t state, state_nxt;

  logic [3:0]                  col_s1, col_s2, lat_col;
  logic [SW-1:0]               scan_cnt;
  logic [1:0]                  row_idx;
  logic [MW-1:0]               match_cnt, rel_cnt;
  logic [NUM_DIGITS-1:0][3:0]  digits, digits_shift;
  logic [NW-1:0]               count;
  logic [3:0]                  key_new;
  logic tick, col_hit, deb_done, rel_done;
  logic latch, rotate, row_home, fire;

  assign tick     = (scan_cnt == '0);
  assign col_hit  = (col_s2 == lat_col);
  assign deb_done = (match_cnt >= MW'(DEBOUNCE_CNT))
                 || (tick && col_hit && (match_cnt == MW'(DEBOUNCE_CNT - 1)));
  assign rel_done = tick && (col_s2 == COL_NONE) && (rel_cnt == MW'(DEBOUNCE_CNT - 1));
  assign key_new  = {row_idx, onehot_col_idx(lat_col)};
  assign row_out  = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN:     if (tick && single_low(col_s2)) state_nxt = DEBOUNCE;
      DEBOUNCE: begin
        if (deb_done)              state_nxt = HELD;
        else if (tick && !col_hit) state_nxt = SCAN;
      end
      HELD:     if (rel_done) state_nxt = SCAN;
      default:  state_nxt = SCAN;
    endcase
  end

  always_comb begin
    latch    = 1'b0;
    rotate   = 1'b0;
    row_home = 1'b0;
    fire     = 1'b0;
    unique case (state)
      SCAN: begin
        latch  = tick && single_low(col_s2);
        rotate = tick && !single_low(col_s2);
      end
      DEBOUNCE: begin
        fire   = deb_done;
        rotate = !deb_done && tick && !col_hit;
      end
      HELD:    row_home = rel_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1    <= COL_NONE;
      col_s2    <= COL_NONE;
      scan_cnt  <= SCAN_LOAD;
      row_idx   <= '0;
      lat_col   <= COL_NONE;
      match_cnt <= '0;
      rel_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      col_s1    <= col_in;
      col_s2    <= col_s1;
      scan_cnt  <= tick ? SCAN_LOAD : scan_cnt - 1'b1;
      key_valid <= fire;
      if (row_home)    row_idx <= '0;
      else if (rotate) row_idx <= row_idx + 2'd1;
      if (latch) begin
        lat_col   <= col_s2;
        match_cnt <= MW'(1);
      end else if ((state == DEBOUNCE) && tick && col_hit) begin
        match_cnt <= match_cnt + 1'b1;
      end
      if (state != HELD) rel_cnt <= '0;
      else if (tick)     rel_cnt <= (col_s2 == COL_NONE) ? rel_cnt + 1'b1 : '0;
      if (fire) key_code <= key_new;
    end
  end

  // Newest key enters digit 0; the oldest digit falls off the top.
  always_comb begin
    digits_shift    = digits;
    digits_shift[0] = key_new;
    for (int i = 1; i < NUM_DIGITS; i++) digits_shift[i] = digits[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      count  <= '0;
    end else if (clr) begin
      digits <= '0;
      count  <= '0;
    end else if (fire) begin
      digits <= digits_shift;
      count  <= (count == NW'(NUM_DIGITS)) ? count : count + 1'b1;
    end
  end

  seg7_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .CNT_W      (NW)
  ) u_mux (
    .clk   (clk),
    .rst_n (rst_n),
    .digits(digits),
    .count (count),
    .seg   (seg),
    .an    (an)
  );

endmodule
